alu_exec_unit: RTL and testbench

- Execution unit that consumes the 4-bit ALU operation code and 2-bit branch code produced by the ALU control decoder.
- Performs the selected operation on two operands. Simple ops take one cycle; DIV/REM run through an iterative divider.
- Uses valid/ready handshakes on both input and output, so the pipeline stalls cleanly on multi-cycle ops.
- Sits in the EX stage between the decode/operand-fetch register and the EX/MEM register.

---
 rtl/alu_exec_unit.sv | 210 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : EX-stage ALU with valid/ready handshakes and an iterative signed
//            divider. Define ALU_ITER_MUL_EN for a shift-add iterative MUL.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       OP,
    input  logic [1:0]       BR,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             busy
);
    localparam int               c_SHW  = $clog2(WIDTH);
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b0010;
    localparam logic [3:0] c_OP_DIV = 4'b0011;
    localparam logic [3:0] c_OP_REM = 4'b0100;
    localparam logic [3:0] c_OP_OR  = 4'b0101;
    localparam logic [3:0] c_OP_XOR = 4'b0110;
    localparam logic [3:0] c_OP_AND = 4'b0111;
    localparam logic [3:0] c_OP_SHL = 4'b1000;
    localparam logic [3:0] c_OP_SHR = 4'b1001;
    localparam logic [3:0] c_OP_SLT = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic             w_accept, w_last, w_iter_div, w_iter_mul, w_br, w_ovf, w_bzero;
    logic [WIDTH-1:0] w_res, w_mag_a, w_mag_b;
    logic [c_SHW-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo, r_rem, r_dvs;
    logic             r_is_rem, r_neg_q, r_neg_r;
    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic [WIDTH-1:0] w_q_next, w_r_next, w_div_res;
`ifdef ALU_ITER_MUL_EN
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
`endif

    assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready) && rst_n;
    assign busy     = (r_state != S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_LAST);
    assign w_bzero  = (B == '0);
    assign w_ovf    = (A == c_MIN) && (B == '1);
    assign w_mag_a  = A[WIDTH-1] ? -A : A;
    assign w_mag_b  = B[WIDTH-1] ? -B : B;

    // Restoring step: shift in the next dividend bit, keep the trial difference if non-negative
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_q_next  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_r_next  = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_div_res = r_is_rem ? (r_neg_r ? -w_r_next : w_r_next)
                                : (r_neg_q ? -w_q_next : w_q_next);
`ifdef ALU_ITER_MUL_EN
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

    always_comb begin
        w_res      = '0;
        w_br       = 1'b0;
        w_iter_div = 1'b0;
        w_iter_mul = 1'b0;
        case (OP)
            c_OP_ADD: w_res = A + B;
            c_OP_SUB: begin
                w_res = A - B;
                case (BR)
                    2'b00:   w_br = (A == B);
                    2'b01:   w_br = (A != B);
                    2'b10:   w_br = ($signed(A) <  $signed(B));
                    default: w_br = ($signed(A) >= $signed(B));
                endcase
            end
`ifdef ALU_ITER_MUL_EN
            c_OP_MUL: w_iter_mul = 1'b1;
`else
            c_OP_MUL: w_res = A * B;
`endif
            c_OP_DIV: begin
                if (w_bzero)    w_res = '1;
                else if (w_ovf) w_res = A;
                else            w_iter_div = 1'b1;
            end
            c_OP_REM: begin
                if (w_bzero)    w_res = A;
                else if (w_ovf) w_res = '0;
                else            w_iter_div = 1'b1;
            end
            c_OP_OR:  w_res = A | B;
            c_OP_XOR: w_res = A ^ B;
            c_OP_AND: w_res = A & B;
            c_OP_SHL: w_res = A << B[c_SHW-1:0];
            c_OP_SHR: w_res = A >> B[c_SHW-1:0];
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_iter_div)      w_state_next = S_DIV;
                else if (w_accept && w_iter_mul) w_state_next = S_MUL;
            end
            S_DIV, S_MUL: if (w_last) w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`ifdef ALU_ITER_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_quo    <= w_mag_a;
            r_rem    <= '0;
            r_dvs    <= w_mag_b;
            r_is_rem <= (OP == c_OP_REM);
            r_neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r  <= A[WIDTH-1];
`ifdef ALU_ITER_MUL_EN
            r_mcand  <= A;
            r_mplier <= B;
            r_acc    <= '0;
`endif
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == S_DIV) begin
                r_quo <= w_q_next;
                r_rem <= w_r_next;
            end
`ifdef ALU_ITER_MUL_EN
            else begin
                r_acc    <= w_acc_next;
                r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            end
`endif
        end
    end

    // Output register: a load on the same edge as a pop replaces the held value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
        end else if (w_accept && !w_iter_div && !w_iter_mul) begin
            out_valid    <= 1'b1;
            result       <= w_res;
            zero         <= (w_res == '0);
            branch_taken <= w_br;
        end else if ((r_state == S_DIV) && w_last) begin
            out_valid    <= 1'b1;
            result       <= w_div_res;
            zero         <= (w_div_res == '0);
            branch_taken <= 1'b0;
`ifdef ALU_ITER_MUL_EN
        end else if ((r_state == S_MUL) && w_last) begin
            out_valid    <= 1'b1;
            result       <= w_acc_next;
            zero         <= (w_acc_next == '0);
            branch_taken <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit (directed cases plus random stream).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;
    localparam int W = 32;
    localparam logic [W-1:0] c_MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   OP = '0;
    logic [1:0]   BR = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         branch_taken;
    logic         busy;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .OP(OP), .BR(BR), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken), .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         br;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   npop  = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [1:0] br,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa, sb;
        logic [W-1:0] r;
        sa = a; sb = b; r = '0; e.br = 1'b0;
        case (op)
            4'd0:  r = a + b;
            4'd1: begin
                r = a - b;
                case (br)
                    2'd0:    e.br = (a == b);
                    2'd1:    e.br = (a != b);
                    2'd2:    e.br = (sa < sb);
                    default: e.br = (sa >= sb);
                endcase
            end
            4'd2:  r = a * b;
            4'd3:  if (b == '0) r = '1; else if (a == c_MIN && b == '1) r = a; else r = sa / sb;
            4'd4:  if (b == '0) r = a;  else if (a == c_MIN && b == '1) r = '0; else r = sa % sb;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = a & b;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        e.res = r;
        e.z   = (r == '0);
        return e;
    endfunction

    // Scoreboard: push on accepted input, pop on output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_val("unexpected_out", W'(1), W'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_val("sb_result", result, e.res);
                    check_val("sb_zero", W'(zero), W'(e.z));
                    check_val("sb_branch", W'(branch_taken), W'(e.br));
                end
                npop++;
            end
            if (in_valid && in_ready) q.push_back(model(OP, BR, A, B));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [1:0] br,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        OP = op; BR = br; A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_val("issue_timeout", W'(n), W'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Issue one op, measure accept-to-out_valid latency, busy cycles and in_ready while busy
    task automatic run1(input string tag, input logic [3:0] op, input logic [1:0] br,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_res);
        int lat = 1;
        int nbusy = 0;
        int irdy = 0;
        issue(op, br, a, b);
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            if (in_ready) irdy++;
            @(posedge clk);
            #1 lat++;
        end
        check_val({tag, "_lat"}, W'(lat), W'(exp_lat));
        check_val({tag, "_busy_cycles"}, W'(nbusy), W'(exp_lat - 1));
        check_val({tag, "_in_ready_busy"}, W'(irdy), W'(0));
        check_val({tag, "_res"}, result, exp_res);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1 check_val("drain_left", W'(q.size()), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", W'(in_ready), W'(0));
        check_val("rst_out_valid", W'(out_valid), W'(0));
        check_val("rst_result", result, W'(0));
        check_val("rst_zero", W'(zero), W'(0));
        check_val("rst_branch", W'(branch_taken), W'(0));
        check_val("rst_busy", W'(busy), W'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        run1("add", 4'd0, 2'd0, 32'd5, 32'd7, 1, 32'd12);
        check_val("add_zero", W'(zero), W'(0));
        run1("sub_lt", 4'd1, 2'd2, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFE);
        check_val("sub_lt_br", W'(branch_taken), W'(1));
        run1("sub_eq", 4'd1, 2'd0, 32'd9, 32'd9, 1, 32'd0);
        check_val("sub_eq_zero", W'(zero), W'(1));
        check_val("sub_eq_br", W'(branch_taken), W'(1));
        run1("div", 4'd3, 2'd0, -32'sd7, 32'd2, 33, 32'hFFFF_FFFD);
        run1("rem", 4'd4, 2'd0, -32'sd7, 32'd2, 33, 32'hFFFF_FFFF);
        run1("div0", 4'd3, 2'd0, 32'd10, 32'd0, 1, 32'hFFFF_FFFF);
        run1("rem0", 4'd4, 2'd0, 32'd10, 32'd0, 1, 32'd10);
        run1("div_ovf", 4'd3, 2'd0, c_MIN, 32'hFFFF_FFFF, 1, c_MIN);
        run1("undef_op", 4'd13, 2'd0, 32'd3, 32'd4, 1, 32'd0);
        drain();

        // Back-to-back stream must deliver one result per cycle
        begin
            int p0;
            p0 = npop;
            issue(4'd0, 2'd0, 32'd2, 32'd3);
            issue(4'd8, 2'd0, 32'd1, 32'd35);
            check_val("shl_res", result, 32'd8);
            issue(4'd10, 2'd0, 32'hFFFF_FFFF, 32'd0);
            check_val("slt_res", result, 32'd1);
            check_val("stream_pops_2", W'(npop - p0), W'(2));
            @(negedge clk);
            #1 check_val("stream_pops_3", W'(npop - p0), W'(3));
        end
        drain();

        // Output stall: result held stable and no new accept
        begin
            int unstable = 0;
            int irdy = 0;
            out_ready = 1'b0;
            issue(4'd0, 2'd0, 32'd3, 32'd4);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                if (!out_valid || result !== 32'd7) unstable++;
                if (in_ready) irdy++;
            end
            check_val("stall_stable", W'(unstable), W'(0));
            check_val("stall_in_ready", W'(irdy), W'(0));
            out_ready = 1'b1;
            #1 check_val("stall_release_ready", W'(in_ready), W'(1));
        end
        drain();

        // Reset in the middle of a divide discards it
        issue(4'd3, 2'd0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_out_valid", W'(out_valid), W'(0));
        check_val("midrst_busy", W'(busy), W'(0));
        check_val("midrst_in_ready", W'(in_ready), W'(0));
        q.delete();
        rst_n = 1'b1;
        run1("post_rst_add", 4'd0, 2'd0, 32'd1, 32'd1, 1, 32'd2);
        drain();

        // Random stream, including ops held while a divide is busy
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? c_MIN : W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 9));
                2:       rb = '1;
                default: rb = W'($urandom);
            endcase
            issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), ra, rb);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
